// File: rtl/uart_rx_loader.sv
// Program-image loader: packs bytes from a UART receiver into big-endian
// 32-bit words and writes each one to memory, ending on a word limit or idle timeout.
module uart_rx_loader #(
  parameter int WORD_COUNT     = 256,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              rx_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              timeout_err
);

  localparam int              TO_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_FIRE    = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W+1)'(WORD_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                rx_done_q, rx_done_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                got_byte_q, got_byte_d;
  logic                rx_enable_q, rx_enable_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic                strb;
  logic [31:0]         shifted;
  logic [31:0]         padded;

  assign strb    = rx_done & ~rx_done_q;
  assign shifted = {word_q[23:0], rx_data};

  // A partial word is left-justified: the oldest byte lands in [31:24].
  always_comb begin
    padded = '0;
    case (byte_idx_q)
      2'd1:    padded = {word_q[7:0], 24'h0};
      2'd2:    padded = {word_q[15:0], 16'h0};
      default: padded = {word_q[23:0], 8'h0};
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves one unassigned and infers a latch.
    state_d       = state_q;
    rx_done_d     = rx_done;
    word_d        = word_q;
    byte_idx_d    = byte_idx_q;
    to_cnt_d      = to_cnt_q;
    got_byte_d    = got_byte_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = '0;
    word_cnt_d    = word_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RECV;
          mem_addr_d    = '0;
          word_cnt_d    = '0;
          byte_idx_d    = '0;
          timeout_err_d = 1'b0;
          to_cnt_d      = '0;
          got_byte_d    = 1'b0;
          word_d        = '0;
        end
      end

      S_RECV: begin
        if (strb) begin
          word_d     = shifted;
          to_cnt_d   = '0;
          got_byte_d = 1'b1;
          if (byte_idx_q == 2'd3) begin
            state_d     = S_WRITE;
            byte_idx_d  = '0;
            mem_wdata_d = shifted;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (got_byte_q) begin
          if (to_cnt_q >= TO_FIRE) begin
            if (byte_idx_q == 2'd0) begin
              state_d = S_DONE;
            end else begin
              state_d       = S_WRITE;
              timeout_err_d = 1'b1;
              mem_wdata_d   = padded;
              byte_idx_d    = '0;
            end
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        mem_addr_d = mem_addr_q + 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
        state_d    = (word_cnt_d == WORD_LIMIT || timeout_err_q) ? S_DONE : S_RECV;
        // Idle time keeps accruing across the write so the timeout is measured from the last byte.
        if (strb) begin
          word_d     = shifted;
          byte_idx_d = 2'd1;
          to_cnt_d   = '0;
          got_byte_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    rx_enable_d = (state_d == S_RECV) || (state_d == S_WRITE);
    busy_d      = (state_d == S_RECV) || (state_d == S_WRITE);
    mem_we_d    = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rx_done_q     <= 1'b0;
      word_q        <= '0;
      byte_idx_q    <= '0;
      to_cnt_q      <= '0;
      got_byte_q    <= 1'b0;
      rx_enable_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      word_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_done_q     <= rx_done_d;
      word_q        <= word_d;
      byte_idx_q    <= byte_idx_d;
      to_cnt_q      <= to_cnt_d;
      got_byte_q    <= got_byte_d;
      rx_enable_q   <= rx_enable_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      word_cnt_q    <= word_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign rx_enable   = rx_enable_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign word_cnt    = word_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Self-checking bench for uart_rx_loader: vector table, directed sessions and
// random sessions scored against a byte-list model of the expected memory writes.
module tb_uart_rx_loader;

  localparam int WC = 4;
  localparam int AW = 8;
  localparam int TO = 50;

  logic          sysclk = 1'b0;
  logic          reset, start, rx_done;
  logic [7:0]    rx_data;
  logic          rx_enable, mem_we, busy, done, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_cnt;

  uart_rx_loader #(.WORD_COUNT(WC), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .sysclk(sysclk), .reset(reset), .start(start), .rx_done(rx_done), .rx_data(rx_data),
    .rx_enable(rx_enable), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .word_cnt(word_cnt), .timeout_err(timeout_err)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic       rst_n;
    logic       st;
    logic       rxd;
    logic [7:0] dat;
    logic       e_busy;
    logic       e_en;
    logic       e_done;
    logic       e_we;
    logic [AW:0] e_cnt;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_strb = 0;
  logic       prev_we = 1'b0;
  wr_t        act_wr[$];
  wr_t        exp_wr[$];
  logic [7:0] sent[$];
  int         exp_cnt;
  logic       exp_terr;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge sysclk) begin
    if (mem_we === 1'b1) begin
      wr_t w;
      check("we_not_back_to_back", {63'd0, prev_we}, 64'd0);
      check("we_addr_in_range", {63'd0, (int'(mem_addr) < WC)}, 64'd1);
      w.addr = mem_addr;
      w.data = mem_wdata;
      act_wr.push_back(w);
    end
    prev_we <= (mem_we === 1'b1);
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data   = b;
    rx_done   = 1'b1;
    last_strb = cyc;
    sent.push_back(b);
    tick();
    rx_done = 1'b0;
    repeat (gap) tick();
  endtask

  // Expected writes derived from the byte list alone: whole words in order,
  // capped at WC words, then a zero-padded partial word if one is left over.
  task automatic run_model();
    int   n    = sent.size();
    int   full = n / 4;
    int   rem  = n % 4;
    wr_t  w;
    exp_wr.delete();
    exp_terr = 1'b0;
    if (full >= WC) begin
      full = WC;
      rem  = 0;
    end
    for (int i = 0; i < full; i++) begin
      w.addr = AW'(i);
      w.data = {sent[4*i], sent[4*i+1], sent[4*i+2], sent[4*i+3]};
      exp_wr.push_back(w);
    end
    if (rem != 0) begin
      w.addr = AW'(full);
      w.data = 32'h0;
      for (int k = 0; k < rem; k++) w.data = w.data | (32'(sent[4*full+k]) << (24 - 8*k));
      exp_wr.push_back(w);
      exp_terr = 1'b1;
    end
    exp_cnt = exp_wr.size();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, act_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), act_wr[i].addr, exp_wr[i].addr);
      check($sformatf("%s_data%0d", tag, i), act_wr[i].data, exp_wr[i].data);
    end
  endtask

  task automatic start_session(input string tag);
    act_wr.delete();
    sent.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_rx_en"}, rx_enable, 1);
    check({tag, "_start_done_clr"}, done, 0);
    check({tag, "_start_addr0"}, mem_addr, 0);
    check({tag, "_start_cnt0"}, word_cnt, 0);
  endtask

  // exp_elapsed < 0 skips the end-of-session latency check.
  task automatic finish_session(input string tag, input int exp_elapsed);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    run_model();
    check({tag, "_done"}, done, 1);
    if (exp_elapsed >= 0) check({tag, "_done_latency"}, cyc - last_strb, exp_elapsed);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_word_cnt"}, word_cnt, exp_cnt);
    check({tag, "_timeout_err"}, timeout_err, exp_terr);
    check_writes(tag);
  endtask

  vec_t vecs[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00;

    //           rst  st   rxd  dat     busy en   done we   cnt
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};

    for (int i = 0; i < 7; i++) begin
      reset = vecs[i].rst_n; start = vecs[i].st; rx_done = vecs[i].rxd; rx_data = vecs[i].dat;
      tick();
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_rx_enable", i), rx_enable, vecs[i].e_en);
      check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].e_we);
      check($sformatf("vec%0d_word_cnt", i), word_cnt, vecs[i].e_cnt);
      if (i == 0) begin
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        check("reset_terr", timeout_err, 0);
      end
    end
    start = 1'b0;

    // No byte yet this session: the controller must wait indefinitely.
    repeat (120) tick();
    check("no_timeout_before_byte_busy", busy, 1);
    check("no_timeout_before_byte_done", done, 0);

    // rx_done held high for many cycles yields one byte only.
    act_wr.delete();
    sent.delete();
    rx_data = 8'hAA; rx_done = 1'b1; last_strb = cyc; sent.push_back(8'hAA);
    repeat (12) tick();
    rx_done = 1'b0;
    tick();
    send_byte(8'hBB, 2);
    send_byte(8'hCC, 2);
    send_byte(8'hDD, 1);
    finish_session("held", TO);

    // Full session: sixteen bytes fill WC words, a seventeenth is ignored.
    start_session("full");
    for (int i = 0; i < 15; i++) send_byte(8'(i), 1 + (i % 3));
    rx_data = 8'h0F; rx_done = 1'b1; last_strb = cyc; sent.push_back(8'h0F);
    tick();
    rx_done = 1'b0;
    check("full_last_we", mem_we, 1);
    check("full_last_addr", mem_addr, 3);
    check("full_last_data", mem_wdata, 32'h0C0D0E0F);
    check("full_last_cnt_pending", word_cnt, 3);
    tick();
    check("full_done_next", done, 1);
    check("full_we_drop", mem_we, 0);
    check("full_rx_en_off", rx_enable, 0);
    send_byte(8'h10, 3);
    finish_session("full", -1);

    start_session("clean");
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), (i == 7) ? 1 : 2 + i);
    finish_session("clean", TO);

    start_session("partial");
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), (i == 5) ? 1 : 3);
    finish_session("partial", TO + 1);

    // Reset two bytes into a word: nothing is written, all returns to IDLE.
    start_session("rst");
    send_byte(8'hE1, 2);
    send_byte(8'hE2, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_rx_en", rx_enable, 0);
    check("rst_done", done, 0);
    check("rst_cnt", word_cnt, 0);
    repeat (80) tick();
    check("rst_no_write", act_wr.size(), 0);
    check("rst_idle_done", done, 0);
    start_session("after_rst");
    for (int i = 0; i < 4; i++) send_byte(8'h01 + 8'(i), 2);
    finish_session("after_rst", TO);

    for (int s = 0; s < 8; s++) begin
      int nb = $urandom_range(1, 20);
      start_session($sformatf("rnd%0d", s));
      for (int i = 0; i < nb; i++) send_byte(8'($urandom_range(0, 255)), (i == nb - 1) ? 1 : $urandom_range(1, 20));
      finish_session($sformatf("rnd%0d", s), (nb >= 4*WC) ? -1 : ((nb % 4 != 0) ? TO + 1 : TO));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_loader.md
# uart_rx_loader

Controller that sequences the UART byte receiver to load a program image into word-addressed memory. It arms the receiver on a start pulse and assembles received bytes into 32-bit big-endian words. Each completed word is written to memory through a one-cycle write strobe. It terminates on a word-count limit or on an inter-byte idle timeout. It sits between the UART receiver and the instruction/data memory write port of the CPU.

## Interface
- WORD_COUNT, 256: maximum words loaded per session; must be ≥1.
- ADDR_W, 8: width of mem_addr; 2^ADDR_W ≥ WORD_COUNT.
- TIMEOUT_CYCLES, 1000000: sysclk cycles of no byte activity that end a session; must be ≥2.
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  session start request, sampled each cycle.
- rx_done  in  1  receiver byte-complete flag; rising edge marks a new byte.
- rx_data  in  8  received byte; stable while rx_done is high.
- rx_enable  out  1  enable to the receiver.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address of the current or next write.
- mem_wdata  out  32  assembled word; valid while mem_we=1.
- busy  out  1  session in progress.
- done  out  1  session finished; held until the next start.
- word_cnt  out  ADDR_W+1  words written this session.
- timeout_err  out  1  session ended with a partial word.

## Operation
- Reset (reset=0 at a clock edge) drives the FSM to IDLE and clears every output, the shift register, byte_idx, the timeout counter and rx_done_q. Reset mid-session discards any partial word, and no write is issued.
- Byte strobe: rx_done_q is a register of rx_done. strb = rx_done & ~rx_done_q. rx_data is captured in the cycle strb=1.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: rx_enable=0, busy=0. start=1 leads to RECV. Entering RECV clears mem_addr, word_cnt, byte_idx, timeout_err and the timeout counter.
- RECV: rx_enable=1, busy=1.
  - On strb, shift {word[23:0], rx_data}; the first byte ends in [31:24].
  - On strb, byte_idx increments and the timeout counter clears.
  - On strb with byte_idx==3, go to WRITE and reset byte_idx to 0.
- WRITE (exactly one cycle): mem_we=1, mem_wdata=word, mem_addr=current address.
  - On the next edge, mem_addr and word_cnt increment.
  - If word_cnt then equals WORD_COUNT, go to DONE; otherwise go to RECV.
  - A strb during WRITE is captured into byte lane 0 of the next word.
- Timeout: the counter runs in RECV only after the first byte of the session, and clears on each strb. When it reaches TIMEOUT_CYCLES-1:
  - If byte_idx==0, go to DONE with timeout_err=0, which is a normal end of stream.
  - If byte_idx≠0, left-justify the partial bytes and zero-fill the low bytes, then go to WRITE with timeout_err set. After that write, go to DONE.
  - Before the first byte there is no timeout; the controller waits indefinitely.
- DONE: rx_enable=0, busy=0, done=1. mem_addr and word_cnt hold.
  - start=1 begins a new session from address 0, clearing done in the same transition.
- start in RECV or WRITE is ignored.
- A strb outside RECV and WRITE is ignored, and no data is captured.

## Timing
- start sampled at edge N gives busy=1 and rx_enable=1 from edge N onward.
- The 4th byte with strb at cycle N gives mem_we=1 during cycle N+1. mem_addr and word_cnt are updated after edge N+2.
- mem_we is never high for two consecutive cycles.
- The last write of a WORD_COUNT session is followed by done=1 in the next cycle.
- A timeout with no partial word gives done=1 exactly TIMEOUT_CYCLES cycles after the last strb cycle.
- A timeout with a partial word adds one WRITE cycle before done=1.
- Wrap-around: word_cnt saturates at WORD_COUNT; mem_addr never exceeds WORD_COUNT-1 during a write.

## Test plan
Scenarios use WORD_COUNT=4 and TIMEOUT_CYCLES=50.
- Reset then idle: all outputs are 0 and rx_enable=0, even with rx_done toggling.
- Full session: start, then 16 bytes 0x00..0x0F. Required: four writes of 0x00010203@0, 0x04050607@1, 0x08090A0B@2 and 0x0C0D0E0F@3, then done=1, word_cnt=4, timeout_err=0. A 17th byte is ignored.
- Clean end of stream: 8 bytes 0xA0..0xA7, then idle. Required: writes 0xA0A1A2A3@0 and 0xA4A5A6A7@1; done=1 and timeout_err=0 fifty cycles after the last strb.
- Partial word: 6 bytes 0x11..0x16, then idle. Required: writes 0x11121314@0 and 0x15160000@1 (padded); word_cnt=2, timeout_err=1.
- Restart and reset mid-session:
  - Start again from DONE: mem_addr restarts at 0 and done clears.
  - Hold rx_done high for many cycles: exactly one byte is captured.
  - Assert reset after 2 bytes: no write occurs and everything returns to IDLE.
